// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_unit_pkg;

  localparam int unsigned XLEN = 16;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 16'h0000;

  typedef enum logic [1:0] {
    ISSUE = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

  // Wraps modulo 2^XLEN; no carry is reported.
  function automatic logic [XLEN-1:0] pc_add(input logic [XLEN-1:0] a,
                                             input logic [XLEN-1:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// One-entry {instr, pc} register with valid; load beats drain, flush beats both.
module fetch_buf
  import fetch_unit_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_load,
  input  logic            i_flush,
  input  logic            i_ready,
  input  logic [XLEN-1:0] i_instr,
  input  logic [XLEN-1:0] i_pc,
  output logic            o_valid,
  output logic [XLEN-1:0] o_instr,
  output logic [XLEN-1:0] o_pc
);

  logic            r_valid;
  logic [XLEN-1:0] r_instr;
  logic [XLEN-1:0] r_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_instr <= '0;
      r_pc    <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, single-outstanding memory request FSM,
// output buffer to decode and a hold slot for responses decode cannot take.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [XLEN-1:0] PC_STEP  = 16'd1
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_valid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            instr_ready,
  output logic [XLEN-1:0] PC
);

  fetch_state_t    r_state;
  fetch_state_t    w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_nxt;

  logic            w_out_free;
  logic            w_resp_take;
  logic            w_out_load;
  logic            w_hold_load;
  logic            w_hold_take;
  logic            w_hold_valid;
  logic [XLEN-1:0] w_hold_instr;
  logic [XLEN-1:0] w_hold_pc;
  logic [XLEN-1:0] w_out_instr;
  logic [XLEN-1:0] w_out_pc;

  assign w_out_free  = !instr_valid || instr_ready;
  assign w_resp_take = (r_state == WAIT) && imem_valid && !redirect_valid;
  assign w_hold_load = w_resp_take && !w_out_free;
  assign w_hold_take = (r_state == HOLD) && instr_ready && w_hold_valid && !redirect_valid;
  assign w_out_load  = (w_resp_take && w_out_free) || w_hold_take;
  assign w_out_instr = w_hold_take ? w_hold_instr : imem_rdata;
  assign w_out_pc    = w_hold_take ? w_hold_pc : r_pc;

  // PC only advances once the instruction lands in the output buffer,
  // so the hold slot carries the not-yet-advanced PC.
  always_comb begin
    w_pc_nxt = r_pc;
    if (redirect_valid) begin
      w_pc_nxt = redirect_pc;
    end else if (w_out_load) begin
      w_pc_nxt = pc_add(r_pc, PC_STEP);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ISSUE: w_state_nxt = redirect_valid ? ISSUE : WAIT;
      WAIT: begin
        if (redirect_valid) begin
          w_state_nxt = imem_valid ? ISSUE : DRAIN;
        end else if (imem_valid) begin
          w_state_nxt = w_out_free ? ISSUE : HOLD;
        end
      end
      HOLD: begin
        if (redirect_valid || w_hold_take) begin
          w_state_nxt = ISSUE;
        end
      end
      DRAIN: w_state_nxt = imem_valid ? ISSUE : DRAIN;
      default: w_state_nxt = ISSUE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ISSUE;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  fetch_buf u_out_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_out_load),
    .i_flush (redirect_valid),
    .i_ready (instr_ready),
    .i_instr (w_out_instr),
    .i_pc    (w_out_pc),
    .o_valid (instr_valid),
    .o_instr (instr),
    .o_pc    (instr_pc)
  );

  fetch_buf u_hold_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_hold_load),
    .i_flush (redirect_valid),
    .i_ready (w_hold_take),
    .i_instr (imem_rdata),
    .i_pc    (r_pc),
    .o_valid (w_hold_valid),
    .o_instr (w_hold_instr),
    .o_pc    (w_hold_pc)
  );

  // Reset state is ISSUE, so the strobe is gated to stay low during reset.
  assign imem_req  = rst_n && (r_state == ISSUE) && !redirect_valid;
  assign imem_addr = r_pc;
  assign PC        = r_pc;

endmodule
